aes_stream_framer: RTL and testbench

- Byte-stream front/back end for the 128-bit AES cipher core.
- Assembles 16-byte key and plaintext groups from an 8-bit handshaked input and drives them to the core's datain/key inputs, holding them stable for the core's fixed pipeline latency.
- Captures the core's dataout after that latency and serialises the ciphertext as 16 bytes on an 8-bit handshaked output.
- Sits between the UART/host byte interface and the cipher core.

---
 rtl/aes_stream_framer.sv | 154 +++++++++++++++
 tb/tb_aes_stream_framer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_framer.sv
// -----------------------------------------------------------------------------
// aes_stream_framer
//
// Byte-stream front/back end for a 128-bit AES cipher core. Incoming bytes are
// packed into 16-byte groups; a group is either a key (loaded into cipher_key)
// or a plaintext block (loaded into cipher_datain). A completed plaintext block
// is held stable for LATENCY cycles, after which the core's ciphertext is
// captured and serialised MSB byte first on the output handshake.
//
// Parameters:
//   LATENCY        core latency from stable datain/key to valid dataout (1..255)
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_byte          input data byte
//   in_valid         in_byte valid
//   in_is_key        group type, sampled with the first byte of each group
//   in_ready         framer accepts a byte this cycle (COLLECT only)
//   out_byte         ciphertext byte
//   out_valid        out_byte valid (SEND only)
//   out_ready        downstream accepts out_byte
//   cipher_datain    plaintext block to the core
//   cipher_key       key to the core
//   cipher_dataout   ciphertext from the core
//   key_valid        a complete key group has been loaded since reset
//   busy             high while waiting on the core or sending ciphertext
// -----------------------------------------------------------------------------
module aes_stream_framer #(
  parameter int LATENCY = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_is_key,
  output logic         in_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] cipher_datain,
  output logic [127:0] cipher_key,
  input  logic [127:0] cipher_dataout,
  output logic         key_valid,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_WAIT    = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(LATENCY - 1);

  state_t         r_state;
  logic [3:0]     r_idx;
  logic           r_is_key;
  logic [7:0]     r_cnt;
  logic [3:0]     r_out_cnt;
  logic [127:0]   r_out_shift;
  logic [127:0]   r_datain;
  logic [127:0]   r_key;
  logic           r_key_valid;
  logic           r_out_valid;
  logic           r_in_ready;
  logic           r_busy;

  logic           w_accept;
  logic           w_grp_key;

  assign w_accept = in_valid & r_in_ready;
  // The group type is taken live from in_is_key on the first byte only;
  // later bytes use the latched type so in_is_key is ignored mid-group.
  assign w_grp_key = (r_idx == 4'd0) ? in_is_key : r_is_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_COLLECT;
      r_idx       <= 4'd0;
      r_is_key    <= 1'b0;
      r_cnt       <= 8'd0;
      r_out_cnt   <= 4'd0;
      r_out_shift <= '0;
      r_datain    <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            if (r_idx == 4'd0) r_is_key <= in_is_key;
            if (w_grp_key) r_key    <= {r_key[119:0], in_byte};
            else           r_datain <= {r_datain[119:0], in_byte};
            if (r_idx == 4'd15) begin
              r_idx <= 4'd0;
              if (w_grp_key) begin
                r_key_valid <= 1'b1;
              end else begin
                r_cnt      <= 8'd0;
                r_state    <= S_WAIT;
                r_in_ready <= 1'b0;
                r_busy     <= 1'b1;
              end
            end else begin
              r_idx <= r_idx + 4'd1;
            end
          end
        end
        S_WAIT: begin
          // Count the cycles the block has been stable; the capture edge
          // closes the LATENCY-th such cycle.
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) begin
            r_out_shift <= cipher_dataout;
            r_out_cnt   <= 4'd0;
            r_out_valid <= 1'b1;
            r_state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            r_out_shift <= {r_out_shift[119:0], 8'h00};
            r_out_cnt   <= r_out_cnt + 4'd1;
            if (r_out_cnt == 4'd15) begin
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_COLLECT;
            end
          end
        end
        default: begin
          r_state     <= S_COLLECT;
          r_idx       <= 4'd0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_byte      = r_out_shift[127:120];
  assign cipher_datain = r_datain;
  assign cipher_key    = r_key;
  assign key_valid     = r_key_valid;
  assign busy          = r_busy;

endmodule

// File: tb/tb_aes_stream_framer.sv
`timescale 1ns/1ps
module tb_aes_stream_framer;

  localparam int L = 10;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Behavioural AES-128 encryption; byte 0 of the block is bits [127:120].
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]], SBOX[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = SBOX[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr + 4*((c+rr)%4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_is_key = 1'b0;
  logic         in_ready;
  logic [7:0]   out_byte;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] cipher_datain;
  logic [127:0] cipher_key;
  logic [127:0] cipher_dataout;
  logic         key_valid;
  logic         busy;

  aes_stream_framer #(.LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .in_byte(in_byte), .in_valid(in_valid), .in_is_key(in_is_key), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .cipher_datain(cipher_datain), .cipher_key(cipher_key), .cipher_dataout(cipher_dataout),
    .key_valid(key_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: ciphertext of the current inputs becomes visible during the
  // L-th cycle those inputs have been stable.
  logic [127:0] core_stg [1:L-1];
  always @(posedge clk) begin
    core_stg[1] <= aes_enc(cipher_datain, cipher_key);
    for (int i = 2; i < L; i++) core_stg[i] <= core_stg[i-1];
  end
  assign cipher_dataout = core_stg[L-1];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0]   part_q [$];
  logic         m_part_key;
  logic [127:0] m_key = '0;
  logic         m_kv = 1'b0;
  logic [127:0] m_pt = '0;
  logic [7:0]   exp_q [$];
  logic [7:0]   got_q [$];
  int           acc_cyc = -1;
  int           done_cyc = -1;
  bit           in_send = 1'b0;
  int           sent = 0;
  bit           chk_rst = 1'b0;
  bit           stall_prev = 1'b0;
  logic [7:0]   prev_byte = 8'h00;

  // Monitor / scoreboard: checks reflect the state after the previous edge,
  // then the model is advanced to what the coming edge will do.
  always @(negedge clk) begin
    logic [127:0] blk;
    logic [127:0] ct;
    if (chk_rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_byte", out_byte, 0);
      chk("rst_datain", cipher_datain, 0);
      chk("rst_key", cipher_key, 0);
      chk_rst = 1'b0;
    end
    chk("key_valid", key_valid, m_kv);
    if (acc_cyc >= 0) begin
      if (cyc <= acc_cyc + L) begin
        chk("wait_busy", busy, 1);
        chk("wait_in_ready", in_ready, 0);
        chk("wait_out_valid", out_valid, 0);
        chk("wait_datain", cipher_datain, m_pt);
        chk("wait_key", cipher_key, m_key);
      end else begin
        chk("latency_out_valid", out_valid, 1);
        acc_cyc = -1;
        in_send = 1'b1;
        sent = 0;
      end
    end
    if (in_send) begin
      chk("send_in_ready", in_ready, 0);
      chk("send_busy", busy, 1);
    end
    if (done_cyc >= 0 && cyc == done_cyc + 1) begin
      chk("after_send_in_ready", in_ready, 1);
      chk("after_send_busy", busy, 0);
      chk("after_send_out_valid", out_valid, 0);
      done_cyc = -1;
    end
    if (stall_prev && out_valid) chk("stall_hold", out_byte, prev_byte);
    stall_prev = out_valid & ~out_ready;
    prev_byte  = out_byte;

    if (rst) begin
      part_q.delete();
      exp_q.delete();
      m_key = '0; m_kv = 1'b0;
      acc_cyc = -1; done_cyc = -1; in_send = 1'b0; sent = 0;
      stall_prev = 1'b0;
      chk_rst = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_byte);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got %0h with nothing expected (cycle %0d)", out_byte, cyc);
        end else begin
          chk("out_byte", out_byte, exp_q.pop_front());
        end
        if (in_send) begin
          sent++;
          if (sent == 16) begin
            in_send = 1'b0;
            done_cyc = cyc;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (part_q.size() == 0) m_part_key = in_is_key;
        part_q.push_back(in_byte);
        if (part_q.size() == 16) begin
          for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = part_q[i];
          part_q.delete();
          if (m_part_key) begin
            m_key = blk;
            m_kv = 1'b1;
          end else begin
            m_pt = blk;
            acc_cyc = cyc;
            ct = aes_enc(blk, m_key);
            for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
          end
        end
      end
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = pattern 1,0,0
  int or_mode = 0;
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk); #1;
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
      endcase
    end
  end

  task automatic drive_group(input logic is_key, input logic [127:0] blk, input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_byte   = blk[127-8*i -: 8];
      in_is_key = (i == 0) ? is_key : ~is_key;
      in_valid  = 1'b1;
      forever begin
        @(negedge clk);
        if (in_ready && !rst) begin
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        guard++;
        if (guard > 2000) begin
          n_chk++; n_fail++;
          $display("FAIL in_ready_timeout: byte %0d never accepted", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !in_send && acc_cyc < 0 && in_ready) return;
    end
    n_chk++; n_fail++;
    $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_got(input string name, input logic [127:0] exp);
    logic [127:0] g;
    g = '0;
    if (got_q.size() != 16) begin
      n_chk++; n_fail++;
      $display("FAIL %s_count: got %0d bytes expected 16", name, got_q.size());
    end else begin
      for (int i = 0; i < 16; i++) g[127-8*i -: 8] = got_q[i];
      chk(name, g, exp);
    end
    got_q.delete();
  endtask

  initial begin
    logic [127:0] k0, p0, c0, rk, rp;
    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    p0 = 128'h00112233445566778899aabbccddeeff;
    c0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    watchdog_arm();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    chk("model_fips_c1", aes_enc(p0, k0), c0);

    // FIPS-197 C.1 through the framer
    or_mode = 0;
    got_q.delete();
    drive_group(1'b1, k0, 16);
    drive_group(1'b0, p0, 16);
    wait_idle();
    chk_got("fips_c1", c0);

    // Same plaintext, same key, with backpressure 1,0,0
    or_mode = 2;
    drive_group(1'b0, p0, 16);
    wait_idle();
    chk_got("reuse_key_stall", c0);

    // Random traffic
    for (int n = 0; n < 8; n++) begin
      or_mode = $urandom_range(0, 2);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) drive_group(1'b1, rk, 16);
      drive_group(1'b0, rp, 16);
      wait_idle();
      got_q.delete();
    end

    // Reset in the 5th WAIT cycle
    or_mode = 0;
    drive_group(1'b0, p0, 16);
    repeat (4) @(posedge clk);
    #1 pulse_rst();
    @(posedge clk); #1;
    got_q.delete();
    drive_group(1'b1, k0, 16);
    drive_group(1'b0, p0, 16);
    wait_idle();
    chk_got("after_wait_rst", c0);

    // Reset at the 3rd SEND byte
    drive_group(1'b0, p0, 16);
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (in_send && sent >= 2) break;
    end
    pulse_rst();
    @(posedge clk); #1;
    got_q.delete();
    rk = {$urandom, $urandom, $urandom, $urandom};
    rp = {$urandom, $urandom, $urandom, $urandom};
    drive_group(1'b1, rk, 16);
    drive_group(1'b0, rp, 16);
    wait_idle();
    chk_got("after_send_rst", aes_enc(rp, rk));

    // Partial plaintext group discarded by reset
    drive_group(1'b0, {$urandom, $urandom, $urandom, $urandom}, 7);
    pulse_rst();
    got_q.delete();
    rp = {$urandom, $urandom, $urandom, $urandom};
    drive_group(1'b0, rp, 16);
    wait_idle();
    chk_got("partial_then_rst", aes_enc(rp, 128'h0));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic watchdog_arm();
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none
  endtask

endmodule
